// File: rtl/vc_input_buffer_pkg.sv
// rtl/vc_input_buffer_pkg.sv - noc_params_pkg: router defaults, width helpers and flit type
package noc_params_pkg;
   localparam int DEF_FLIT_SIZE   = 16;
   localparam int DEF_BUFFER_SIZE = 8;
   localparam int DEF_VC_NUM      = 2;

   function automatic int clog2(input int value);
      int result;
      int span;
      result = 0;
      span   = value - 1;
      while (span > 0) begin
         result = result + 1;
         span   = span >> 1;
      end
      return result;
   endfunction

   // A single VC still needs a one-bit id field on the ports.
   function automatic int vc_id_width(input int vc_num);
      return (clog2(vc_num) > 1) ? clog2(vc_num) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return clog2(depth + 1);
   endfunction

   typedef logic [DEF_FLIT_SIZE-1:0] flit_t;
endpackage

// File: rtl/vc_input_buffer_if.sv
// rtl/vc_input_buffer_if.sv - input buffer port bundle; error_o present when VC_BUFFER_ERRCHK_EN is defined
interface vc_input_buffer_if
   import noc_params_pkg::*;
#(
   parameter int FLIT_SIZE   = DEF_FLIT_SIZE,
   parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
   parameter int VC_NUM      = DEF_VC_NUM
);
   localparam int VC_ID_W = vc_id_width(VC_NUM);
   localparam int CNT_W   = cnt_width(BUFFER_SIZE);

   logic [FLIT_SIZE-1:0]      data_i;
   logic                      write_i;
   logic [VC_ID_W-1:0]        write_vc_i;
   logic                      read_i;
   logic [VC_ID_W-1:0]        read_vc_i;
   logic [FLIT_SIZE-1:0]      data_o;
   logic [VC_NUM-1:0]         full_o;
   logic [VC_NUM-1:0]         empty_o;
   logic [VC_NUM*CNT_W-1:0]   count_o;
   logic                      credit_o;
   logic [VC_ID_W-1:0]        credit_vc_o;
`ifdef VC_BUFFER_ERRCHK_EN
   logic [1:0]                error_o;

   modport master (
      output data_i, write_i, write_vc_i, read_i, read_vc_i,
      input  data_o, full_o, empty_o, count_o, credit_o, credit_vc_o, error_o
   );
   modport slave (
      input  data_i, write_i, write_vc_i, read_i, read_vc_i,
      output data_o, full_o, empty_o, count_o, credit_o, credit_vc_o, error_o
   );
`else
   modport master (
      output data_i, write_i, write_vc_i, read_i, read_vc_i,
      input  data_o, full_o, empty_o, count_o, credit_o, credit_vc_o
   );
   modport slave (
      input  data_i, write_i, write_vc_i, read_i, read_vc_i,
      output data_o, full_o, empty_o, count_o, credit_o, credit_vc_o
   );
`endif
endinterface

// File: rtl/vc_input_buffer_fifo.sv
// rtl/vc_input_buffer_fifo.sv - flit_fifo: one VC circular buffer; push/pop arrive pre-qualified
module flit_fifo
   import noc_params_pkg::*;
#(
   parameter int FLIT_SIZE = DEF_FLIT_SIZE,
   parameter int DEPTH     = DEF_BUFFER_SIZE,
   parameter int CNT_W     = cnt_width(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [FLIT_SIZE-1:0] data_i,
   input  logic                 push_i,
   input  logic                 pop_i,
   output logic [FLIT_SIZE-1:0] data_o,
   output logic [CNT_W-1:0]     count_o,
   output logic                 full_o,
   output logic                 empty_o
);
   localparam int PTR_W = clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [FLIT_SIZE-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]     wptr_d, wptr_q;
   logic [PTR_W-1:0]     rptr_d, rptr_q;
   logic [CNT_W-1:0]     count_d, count_q;
   logic                 full_d, full_q;
   logic                 empty_d, empty_q;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      // Explicit wrap so depths that are not powers of two work.
      if (push_i) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
      if (pop_i)  rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == FULL_CNT);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= data_i;
   end

   assign data_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;
endmodule

// File: rtl/vc_input_buffer.sv
// rtl/vc_input_buffer.sv - per-port VC input buffer; sticky error_o built when VC_BUFFER_ERRCHK_EN is defined
module vc_input_buffer
   import noc_params_pkg::*;
#(
   parameter int FLIT_SIZE   = DEF_FLIT_SIZE,
   parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
   parameter int VC_NUM      = DEF_VC_NUM
) (
   input  logic              clk,
   input  logic              rst,
   vc_input_buffer_if.slave  bus
);
   localparam int VC_ID_W = vc_id_width(VC_NUM);
   localparam int CNT_W   = cnt_width(BUFFER_SIZE);

   logic [VC_NUM-1:0]    push;
   logic [VC_NUM-1:0]    pop;
   logic [VC_NUM-1:0]    fifo_full;
   logic [VC_NUM-1:0]    fifo_empty;
   logic [FLIT_SIZE-1:0] head  [VC_NUM];
   logic [CNT_W-1:0]     count [VC_NUM];

   logic                 credit_d, credit_q;
   logic [VC_ID_W-1:0]   credit_vc_d, credit_vc_q;

   // Decoding by equality rejects out-of-range VC ids without a separate check.
   always_comb begin
      pop  = '0;
      push = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         pop[v] = bus.read_i && (bus.read_vc_i == VC_ID_W'(v)) && !fifo_empty[v];
      end
      for (int v = 0; v < VC_NUM; v++) begin
         push[v] = bus.write_i && (bus.write_vc_i == VC_ID_W'(v)) && (!fifo_full[v] || pop[v]);
      end
   end

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      flit_fifo #(
         .FLIT_SIZE (FLIT_SIZE),
         .DEPTH     (BUFFER_SIZE),
         .CNT_W     (CNT_W)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .data_i  (bus.data_i),
         .push_i  (push[v]),
         .pop_i   (pop[v]),
         .data_o  (head[v]),
         .count_o (count[v]),
         .full_o  (fifo_full[v]),
         .empty_o (fifo_empty[v])
      );
   end

   always_comb begin
      bus.data_o  = '0;
      bus.count_o = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         if (bus.read_vc_i == VC_ID_W'(v)) bus.data_o = head[v];
         bus.count_o[v*CNT_W +: CNT_W] = count[v];
      end
   end

   always_comb begin
      credit_d    = |pop;
      credit_vc_d = credit_vc_q;
      for (int v = 0; v < VC_NUM; v++) begin
         if (pop[v]) credit_vc_d = VC_ID_W'(v);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credit_q    <= 1'b0;
         credit_vc_q <= '0;
      end else begin
         credit_q    <= credit_d;
         credit_vc_q <= credit_vc_d;
      end
   end

   assign bus.full_o      = fifo_full;
   assign bus.empty_o     = fifo_empty;
   assign bus.credit_o    = credit_q;
   assign bus.credit_vc_o = credit_vc_q;

`ifdef VC_BUFFER_ERRCHK_EN
   logic [1:0] error_d, error_q;

   always_comb begin
      error_d = error_q;
      if (bus.write_i && !(|push)) error_d[0] = 1'b1;
      if (bus.read_i && !(|pop))   error_d[1] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) error_q <= '0;
      else      error_q <= error_d;
   end

   assign bus.error_o = error_q;
`endif
endmodule

// File: tb/tb_vc_input_buffer.sv
// tb/tb_vc_input_buffer.sv - bench for vc_input_buffer at depths 8 and 5 against a queue model
module tb_vc_input_buffer;
   import noc_params_pkg::*;

   localparam int FS = 16;
   localparam int VN = 2;
   localparam int VW = vc_id_width(VN);
   localparam int CA = cnt_width(8);
   localparam int CB = cnt_width(5);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vc_input_buffer_if #(.FLIT_SIZE(FS), .BUFFER_SIZE(8), .VC_NUM(VN)) bus_a ();
   vc_input_buffer_if #(.FLIT_SIZE(FS), .BUFFER_SIZE(5), .VC_NUM(VN)) bus_b ();

   vc_input_buffer #(.FLIT_SIZE(FS), .BUFFER_SIZE(8), .VC_NUM(VN)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   vc_input_buffer #(.FLIT_SIZE(FS), .BUFFER_SIZE(5), .VC_NUM(VN)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   flit_t          mq [2][VN][$];
   int             cap [2];
   logic           exp_credit [2];
   logic [VW-1:0]  exp_cvc [2];
   logic [1:0]     exp_err [2];
   flit_t          exp_head [2];
   logic           head_valid [2];
   flit_t          seen [2];
   int             n_checks = 0;
   int             n_fail = 0;

   task automatic clear_model();
      for (int k = 0; k < 2; k++) begin
         for (int v = 0; v < VN; v++) mq[k][v].delete();
         exp_credit[k] = 1'b0;
         exp_cvc[k]    = '0;
         exp_err[k]    = 2'b00;
      end
   endtask

   // Drives one cycle on both buffers, samples data_o mid-cycle, advances the model.
   task automatic step(input logic w, input logic [VW-1:0] wvc, input flit_t d,
                       input logic r, input logic [VW-1:0] rvc);
      bit r_ok, w_ok;
      bus_a.write_i = w; bus_a.write_vc_i = wvc; bus_a.data_i = d;
      bus_a.read_i  = r; bus_a.read_vc_i  = rvc;
      bus_b.write_i = w; bus_b.write_vc_i = wvc; bus_b.data_i = d;
      bus_b.read_i  = r; bus_b.read_vc_i  = rvc;
      #1;
      seen[0] = bus_a.data_o;
      seen[1] = bus_b.data_o;
      for (int k = 0; k < 2; k++) begin
         head_valid[k] = mq[k][rvc].size() > 0;
         exp_head[k]   = head_valid[k] ? mq[k][rvc][0] : '0;
         r_ok = r && (int'(rvc) < VN) && (mq[k][rvc].size() > 0);
         w_ok = w && (int'(wvc) < VN) && ((mq[k][wvc].size() < cap[k]) || (r_ok && rvc == wvc));
         if (r_ok) void'(mq[k][rvc].pop_front());
         if (w_ok) mq[k][wvc].push_back(d);
         exp_credit[k] = r_ok;
         if (r_ok) exp_cvc[k] = rvc;
         if (w && !w_ok) exp_err[k][0] = 1'b1;
         if (r && !r_ok) exp_err[k][1] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      bus_a.write_i = 0; bus_a.read_i = 0; bus_a.write_vc_i = 0; bus_a.read_vc_i = 0; bus_a.data_i = 0;
      bus_b.write_i = 0; bus_b.read_i = 0; bus_b.write_vc_i = 0; bus_b.read_vc_i = 0; bus_b.data_i = 0;
      clear_model();
      repeat (2) @(negedge clk);
      n_checks++; if (bus_a.empty_o !== 2'b11) begin n_fail++; $display("FAIL reset_empty: got %b want 11", bus_a.empty_o); end
      n_checks++; if (bus_a.full_o !== 2'b00) begin n_fail++; $display("FAIL reset_full: got %b want 00", bus_a.full_o); end
      n_checks++; if (bus_a.count_o !== '0) begin n_fail++; $display("FAIL reset_count: got %h want 0", bus_a.count_o); end
      n_checks++; if (bus_b.empty_o !== 2'b11) begin n_fail++; $display("FAIL reset_empty_b: got %b want 11", bus_b.empty_o); end
      n_checks++; if ({bus_a.credit_o, bus_a.credit_vc_o} !== 2'b00) begin n_fail++; $display("FAIL reset_credit: got %b%b want 00", bus_a.credit_o, bus_a.credit_vc_o); end
`ifdef VC_BUFFER_ERRCHK_EN
      n_checks++; if (bus_a.error_o !== 2'b00) begin n_fail++; $display("FAIL reset_error: got %b want 00", bus_a.error_o); end
`endif
      rst = 1'b1;
   endtask

   task automatic test_basic();
      for (int i = 0; i < 3; i++) step(1, 1, 16'hA001 + 16'(i), 0, 0);
      n_checks++; if (bus_a.count_o[1*CA +: CA] !== CA'(3)) begin n_fail++; $display("FAIL basic_count1: got %0d want 3", bus_a.count_o[1*CA +: CA]); end
      n_checks++; if (bus_a.empty_o[0] !== 1'b1) begin n_fail++; $display("FAIL basic_empty0: got %b want 1", bus_a.empty_o[0]); end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 1);
         n_checks++; if (seen[0] !== 16'hA001 + 16'(i)) begin n_fail++; $display("FAIL basic_data%0d: got %h want %h", i, seen[0], 16'hA001 + 16'(i)); end
         n_checks++; if (seen[1] !== 16'hA001 + 16'(i)) begin n_fail++; $display("FAIL basic_data_b%0d: got %h want %h", i, seen[1], 16'hA001 + 16'(i)); end
         n_checks++; if ({bus_a.credit_o, bus_a.credit_vc_o} !== 2'b11) begin n_fail++; $display("FAIL basic_credit%0d: got %b%b want 11", i, bus_a.credit_o, bus_a.credit_vc_o); end
      end
      step(0, 0, 0, 0, 0);
      n_checks++; if (bus_a.credit_o !== 1'b0) begin n_fail++; $display("FAIL basic_credit_end: got %b want 0", bus_a.credit_o); end
      n_checks++; if (bus_a.empty_o[1] !== 1'b1) begin n_fail++; $display("FAIL basic_empty1: got %b want 1", bus_a.empty_o[1]); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) step(1, 0, 16'hB000 + 16'(i), 0, 0);
      n_checks++; if (bus_a.full_o[0] !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", bus_a.full_o[0]); end
      step(1, 0, 16'hBEEF, 0, 0);
      n_checks++; if (bus_a.count_o[0 +: CA] !== CA'(8)) begin n_fail++; $display("FAIL full_drop_count: got %0d want 8", bus_a.count_o[0 +: CA]); end
`ifdef VC_BUFFER_ERRCHK_EN
      n_checks++; if (bus_a.error_o !== 2'b01) begin n_fail++; $display("FAIL full_overflow: got %b want 01", bus_a.error_o); end
`endif
      step(1, 0, 16'hC000, 1, 0);
      n_checks++; if (seen[0] !== 16'hB000) begin n_fail++; $display("FAIL full_rw_data: got %h want b000", seen[0]); end
      n_checks++; if (bus_a.count_o[0 +: CA] !== CA'(8)) begin n_fail++; $display("FAIL full_rw_count: got %0d want 8", bus_a.count_o[0 +: CA]); end
      n_checks++; if (bus_a.credit_o !== 1'b1) begin n_fail++; $display("FAIL full_rw_credit: got %b want 1", bus_a.credit_o); end
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 1, 0);
         for (int k = 0; k < 2; k++) begin
            if (head_valid[k]) begin
               n_checks++; if (seen[k] !== exp_head[k]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", k, seen[k], exp_head[k]); end
            end
         end
      end
      n_checks++; if (bus_a.empty_o[0] !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", bus_a.empty_o[0]); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 40; i++) begin
         step(($urandom_range(0, 9) < 6), 0, flit_t'($urandom), $urandom_range(0, 1) == 1, 0);
         if (head_valid[1]) begin
            n_checks++; if (seen[1] !== exp_head[1]) begin n_fail++; $display("FAIL wrap_data@%0d: got %h want %h", i, seen[1], exp_head[1]); end
         end
         n_checks++; if (bus_b.count_o[0 +: CB] !== CB'(mq[1][0].size()) || bus_b.count_o[0 +: CB] > CB'(5)) begin
            n_fail++; $display("FAIL wrap_count@%0d: got %0d want %0d", i, bus_b.count_o[0 +: CB], mq[1][0].size());
         end
      end
   endtask

   task automatic test_empty_read();
      while (mq[0][1].size() > 0 || mq[1][1].size() > 0) step(0, 0, 0, 1, 1);
      step(1, 1, 16'hD00D, 1, 1);
      n_checks++; if (bus_a.credit_o !== 1'b0 || bus_b.credit_o !== 1'b0) begin n_fail++; $display("FAIL empty_rd_credit: got %b%b want 00", bus_a.credit_o, bus_b.credit_o); end
      n_checks++; if (bus_a.count_o[1*CA +: CA] !== CA'(1)) begin n_fail++; $display("FAIL empty_rd_count: got %0d want 1", bus_a.count_o[1*CA +: CA]); end
`ifdef VC_BUFFER_ERRCHK_EN
      n_checks++; if (bus_a.error_o[1] !== 1'b1) begin n_fail++; $display("FAIL empty_rd_underflow: got %b want 1", bus_a.error_o[1]); end
`endif
   endtask

   task automatic test_cross();
      step(1, 0, 16'h1234, 1, 1);
      n_checks++; if (seen[0] !== 16'hD00D) begin n_fail++; $display("FAIL cross_data: got %h want d00d", seen[0]); end
      n_checks++; if ({bus_a.credit_o, bus_a.credit_vc_o} !== 2'b11) begin n_fail++; $display("FAIL cross_credit: got %b%b want 11", bus_a.credit_o, bus_a.credit_vc_o); end
      n_checks++; if (bus_a.count_o[1*CA +: CA] !== CA'(0)) begin n_fail++; $display("FAIL cross_count1: got %0d want 0", bus_a.count_o[1*CA +: CA]); end
      n_checks++; if (bus_a.count_o[0 +: CA] !== CA'(mq[0][0].size())) begin n_fail++; $display("FAIL cross_count0: got %0d want %0d", bus_a.count_o[0 +: CA], mq[0][0].size()); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 1) == 1, VW'($urandom_range(0, VN - 1)), flit_t'($urandom),
              $urandom_range(0, 1) == 1, VW'($urandom_range(0, VN - 1)));
         for (int k = 0; k < 2; k++) begin
            if (head_valid[k]) begin
               n_checks++; if (seen[k] !== exp_head[k]) begin n_fail++; $display("FAIL rnd_data[%0d]@%0d: got %h want %h", k, i, seen[k], exp_head[k]); end
            end
         end
         for (int v = 0; v < VN; v++) begin
            n_checks++; if (bus_a.count_o[v*CA +: CA] !== CA'(mq[0][v].size()) || bus_a.full_o[v] !== (mq[0][v].size() == 8) || bus_a.empty_o[v] !== (mq[0][v].size() == 0)) begin
               n_fail++; $display("FAIL rnd_state_a vc%0d@%0d: got cnt %0d f%b e%b want cnt %0d", v, i, bus_a.count_o[v*CA +: CA], bus_a.full_o[v], bus_a.empty_o[v], mq[0][v].size());
            end
            n_checks++; if (bus_b.count_o[v*CB +: CB] !== CB'(mq[1][v].size()) || bus_b.full_o[v] !== (mq[1][v].size() == 5) || bus_b.empty_o[v] !== (mq[1][v].size() == 0)) begin
               n_fail++; $display("FAIL rnd_state_b vc%0d@%0d: got cnt %0d f%b e%b want cnt %0d", v, i, bus_b.count_o[v*CB +: CB], bus_b.full_o[v], bus_b.empty_o[v], mq[1][v].size());
            end
         end
         n_checks++; if (bus_a.credit_o !== exp_credit[0] || (exp_credit[0] && bus_a.credit_vc_o !== exp_cvc[0])) begin
            n_fail++; $display("FAIL rnd_credit_a@%0d: got %b/%0d want %b/%0d", i, bus_a.credit_o, bus_a.credit_vc_o, exp_credit[0], exp_cvc[0]);
         end
         n_checks++; if (bus_b.credit_o !== exp_credit[1] || (exp_credit[1] && bus_b.credit_vc_o !== exp_cvc[1])) begin
            n_fail++; $display("FAIL rnd_credit_b@%0d: got %b/%0d want %b/%0d", i, bus_b.credit_o, bus_b.credit_vc_o, exp_credit[1], exp_cvc[1]);
         end
`ifdef VC_BUFFER_ERRCHK_EN
         n_checks++; if (bus_a.error_o !== exp_err[0] || bus_b.error_o !== exp_err[1]) begin
            n_fail++; $display("FAIL rnd_error@%0d: got %b %b want %b %b", i, bus_a.error_o, bus_b.error_o, exp_err[0], exp_err[1]);
         end
`endif
      end
   endtask

   task automatic test_async_reset();
      pulse_reset();
      for (int i = 0; i < 4; i++) step(1, 0, 16'hE000 + 16'(i), 0, 0);
      step(1, 0, 16'hE004, 1, 0);
      n_checks++; if (bus_a.credit_o !== 1'b1 || bus_a.count_o[0 +: CA] !== CA'(4)) begin
         n_fail++; $display("FAIL arst_setup: got credit %b cnt %0d want 1/4", bus_a.credit_o, bus_a.count_o[0 +: CA]);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (bus_a.credit_o !== 1'b0) begin n_fail++; $display("FAIL arst_credit: got %b want 0", bus_a.credit_o); end
      n_checks++; if (bus_a.count_o !== '0 || bus_b.count_o !== '0) begin n_fail++; $display("FAIL arst_count: got %h %h want 0", bus_a.count_o, bus_b.count_o); end
      n_checks++; if (bus_a.empty_o !== 2'b11 || bus_a.full_o !== 2'b00) begin n_fail++; $display("FAIL arst_flags: got e%b f%b want e11 f00", bus_a.empty_o, bus_a.full_o); end
`ifdef VC_BUFFER_ERRCHK_EN
      n_checks++; if (bus_a.error_o !== 2'b00) begin n_fail++; $display("FAIL arst_error: got %b want 00", bus_a.error_o); end
`endif
      clear_model();
      @(negedge clk);
      rst = 1'b1;
      step(0, 0, 0, 0, 0);
      n_checks++; if (bus_a.credit_o !== 1'b0 || bus_b.credit_o !== 1'b0) begin n_fail++; $display("FAIL arst_no_credit: got %b%b want 00", bus_a.credit_o, bus_b.credit_o); end
      n_checks++; if (bus_a.empty_o !== 2'b11) begin n_fail++; $display("FAIL arst_after_empty: got %b want 11", bus_a.empty_o); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      cap[0] = 8;
      cap[1] = 5;
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_empty_read();
      test_cross();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
